ram_arbiter: RTL and testbench

Shares the single-port 64K x 16 data RAM between the CPU data/stack port and a DMA port used by the I/O side. Each requester uses a req/ack handshake. The arbiter registers the winning request, drives one RAM access, and returns a one-cycle ack with read data. Arbitration is round-robin, plus a CPU lock for atomic read-modify-write sequences such as stack push/pop pairs.

---
 rtl/cpu_pkg.sv | 18 +
 rtl/ram_arbiter_rr_pick2.sv | 26 ++
 rtl/ram_arbiter.sv | 124 ++++++++++++
 tb/tb_ram_arbiter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU-side memory subsystem: arbiter state
// encoding, RAM port owner ids and default RAM geometry.
package cpu_pkg;

  localparam int unsigned DEF_ADDR_W = 16;
  localparam int unsigned DEF_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } arb_state_t;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_CPU  = 2'd1;
  localparam logic [1:0] OWN_DMA  = 2'd2;

endpackage

// File: rtl/ram_arbiter_rr_pick2.sv
// Two-way round-robin pick. req[0] is the CPU, req[1] is the DMA port.
// last_grant = 1 means the DMA port was served last. mask_dma removes the
// DMA request from consideration while the CPU holds a lock.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       mask_dma,
  output logic [1:0] gnt,
  output logic       any
);

  logic [1:0] eff;

  // Single eligible requester wins; on a tie the port not served last wins.
  always_comb begin
    eff = {req[1] & ~mask_dma, req[0]};
    gnt = '0;
    if (eff == 2'b11) begin
      gnt = last_grant ? 2'b01 : 2'b10;
    end else begin
      gnt = eff;
    end
    any = |eff;
  end

endmodule

// File: rtl/ram_arbiter.sv
// Arbiter sharing the single-port data RAM between the CPU data/stack port
// and the DMA port. Each access runs IDLE -> ISSUE -> RESP; the CPU may hold
// a lock across accesses for atomic read-modify-write sequences.
module ram_arbiter
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic              cpu_lock,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_ack,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [1:0]        owner
);

  arb_state_t        state;
  logic              we_q;
  logic              lock_q;
  logic              lock_held;
  logic              last_grant;   // 1 = DMA served last
  logic [DATA_W-1:0] cpu_rdata_q;
  logic [DATA_W-1:0] dma_rdata_q;
  logic [1:0]        gnt;
  logic              any;

  rr_pick2 u_pick (
    .req        ({dma_req, cpu_req}),
    .last_grant (last_grant),
    .mask_dma   (lock_held),
    .gnt        (gnt),
    .any        (any)
  );

  // RAM data arrives in the RESP cycle itself, so read data is forwarded
  // straight from the RAM while ack is high and held in a register after.
  always_comb begin
    cpu_rdata = (cpu_ack && !we_q) ? ram_rdata : cpu_rdata_q;
    dma_rdata = (dma_ack && !we_q) ? ram_rdata : dma_rdata_q;
  end

  // Access sequencer: latch the winner, strobe the RAM, then acknowledge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      owner       <= OWN_NONE;
      ram_en      <= 1'b0;
      ram_we      <= 1'b0;
      ram_addr    <= '0;
      ram_wdata   <= '0;
      cpu_ack     <= 1'b0;
      dma_ack     <= 1'b0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
      we_q        <= 1'b0;
      lock_q      <= 1'b0;
      lock_held   <= 1'b0;
      last_grant  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (any) begin
            if (gnt[0]) begin
              owner     <= OWN_CPU;
              we_q      <= cpu_we;
              lock_q    <= cpu_lock;
              ram_we    <= cpu_we;
              ram_addr  <= cpu_addr;
              ram_wdata <= cpu_wdata;
            end else begin
              owner     <= OWN_DMA;
              we_q      <= dma_we;
              lock_q    <= 1'b0;
              ram_we    <= dma_we;
              ram_addr  <= dma_addr;
              ram_wdata <= dma_wdata;
            end
            ram_en <= 1'b1;
            state  <= ISSUE;
          end
        end
        ISSUE: begin
          ram_en  <= 1'b0;
          ram_we  <= 1'b0;
          cpu_ack <= (owner == OWN_CPU);
          dma_ack <= (owner == OWN_DMA);
          state   <= RESP;
        end
        RESP: begin
          cpu_ack <= 1'b0;
          dma_ack <= 1'b0;
          if (owner == OWN_CPU) begin
            lock_held  <= lock_q;
            last_grant <= 1'b0;
            if (!we_q) cpu_rdata_q <= ram_rdata;
          end else begin
            last_grant <= 1'b1;
            if (!we_q) dma_rdata_q <= ram_rdata;
          end
          owner <= OWN_NONE;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural synchronous RAM.
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_we, cpu_lock;
  logic [15:0] cpu_addr, cpu_wdata;
  logic        cpu_ack;
  logic [15:0] cpu_rdata;
  logic        dma_req, dma_we;
  logic [15:0] dma_addr, dma_wdata;
  logic        dma_ack;
  logic [15:0] dma_rdata;
  logic        ram_en, ram_we;
  logic [15:0] ram_addr, ram_wdata;
  logic [15:0] ram_rdata = '0;
  logic [1:0]  owner;

  logic [15:0] mem [0:65535];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ram_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_lock(cpu_lock),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we),
    .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_ack(dma_ack), .dma_rdata(dma_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .owner(owner)
  );

  // Single-port synchronous RAM: read data one cycle after ram_en.
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_inputs();
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_lock = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
  endtask

  initial begin
    mem[16'h1234] = 16'hBEEF;
    mem[16'h0010] = 16'h0000;
    mem[16'hFFFF] = 16'h5A5A;
    mem[16'h0100] = 16'h1111;
    mem[16'h0200] = 16'h0000;
    clear_inputs();
    rst_n = 1'b0;
    step(2);

    // Reset state
    check("rst_owner", owner, 0);
    check("rst_ram_en", ram_en, 0);
    check("rst_ram_we", ram_we, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_wdata", ram_wdata, 0);
    check("rst_cpu_ack", cpu_ack, 0);
    check("rst_dma_ack", dma_ack, 0);
    check("rst_cpu_rdata", cpu_rdata, 0);
    check("rst_dma_rdata", dma_rdata, 0);
    rst_n = 1'b1;

    // Single CPU read of 0x1234
    cpu_req = 1'b1; cpu_addr = 16'h1234;
    step(1);
    check("t1_ram_en", ram_en, 1);
    check("t1_ram_addr", ram_addr, 16'h1234);
    check("t1_ram_we", ram_we, 0);
    check("t1_owner", owner, 1);
    check("t1_early_ack", cpu_ack, 0);
    step(1);
    check("t1_cpu_ack", cpu_ack, 1);
    check("t1_cpu_rdata", cpu_rdata, 16'hBEEF);
    check("t1_dma_ack", dma_ack, 0);
    check("t1_ram_en_off", ram_en, 0);
    cpu_req = 1'b0;
    step(1);
    check("t1_ack_pulse", cpu_ack, 0);
    step(1);
    check("t1_no_reserve", ram_en, 0);

    // Tie from reset: CPU write then DMA read of the same word
    do_reset();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0010; cpu_wdata = 16'h00AA;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h0010;
    step(1);
    check("t2_owner_cpu", owner, 1);
    check("t2_ram_we", ram_we, 1);
    check("t2_ram_wdata", ram_wdata, 16'h00AA);
    step(1);
    check("t2_cpu_ack", cpu_ack, 1);
    check("t2_dma_ack_lo", dma_ack, 0);
    cpu_req = 1'b0; cpu_we = 1'b0;
    step(1);
    check("t2_idle_acks", {cpu_ack, dma_ack}, 0);
    step(1);
    check("t2_owner_dma", owner, 2);
    check("t2_ram_en", ram_en, 1);
    step(1);
    check("t2_dma_ack", dma_ack, 1);
    check("t2_dma_rdata", dma_rdata, 16'h00AA);
    check("t2_cpu_ack_lo", cpu_ack, 0);
    dma_req = 1'b0;
    step(1);

    // Continuous contention: acks alternate every 3 cycles
    do_reset();
    clear_inputs();
    cpu_req = 1'b1; cpu_addr = 16'h1234;
    dma_req = 1'b1; dma_addr = 16'h0010;
    for (int k = 0; k < 5; k++) begin
      step(2);
      check("t3_cpu_ack", cpu_ack, (k % 2 == 0) ? 1 : 0);
      check("t3_dma_ack", dma_ack, (k % 2 == 1) ? 1 : 0);
      if (k % 2 == 0) check("t3_cpu_rdata", cpu_rdata, 16'hBEEF);
      else            check("t3_dma_rdata", dma_rdata, 16'h00AA);
      step(1);
      check("t3_gap", {cpu_ack, dma_ack}, 0);
    end
    clear_inputs();
    step(1);

    // CPU lock across read/write of 0xFFFF with DMA waiting
    do_reset();
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h0100;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_lock = 1'b1; cpu_addr = 16'hFFFF;
    step(1);
    check("t4_owner_rd", owner, 1);
    step(1);
    check("t4_cpu_ack_rd", cpu_ack, 1);
    check("t4_cpu_rdata", cpu_rdata, 16'h5A5A);
    cpu_we = 1'b1; cpu_wdata = 16'h1357; cpu_lock = 1'b0;
    step(1);
    check("t4_dma_ack_lo1", dma_ack, 0);
    step(1);
    check("t4_owner_locked", owner, 1);
    check("t4_ram_we", ram_we, 1);
    check("t4_ram_addr", ram_addr, 16'hFFFF);
    step(1);
    check("t4_cpu_ack_wr", cpu_ack, 1);
    check("t4_dma_ack_lo2", dma_ack, 0);
    cpu_req = 1'b0; cpu_we = 1'b0;
    step(1);
    check("t4_mem_ffff", mem[16'hFFFF], 16'h1357);
    step(1);
    check("t4_owner_dma", owner, 2);
    check("t4_dma_addr", ram_addr, 16'h0100);
    step(1);
    check("t4_dma_ack", dma_ack, 1);
    check("t4_dma_rdata", dma_rdata, 16'h1111);
    dma_req = 1'b0;
    step(1);

    // CPU write (last_grant becomes CPU), then reset during DMA write ISSUE
    clear_inputs();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0200; cpu_wdata = 16'h7777;
    step(2);
    check("t5_cpu_ack", cpu_ack, 1);
    cpu_req = 1'b0; cpu_we = 1'b0;
    step(1);
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'h0100; dma_wdata = 16'hCAFE;
    step(1);
    check("t5_issue_en", ram_en, 1);
    check("t5_issue_we", ram_we, 1);
    rst_n = 1'b0;
    dma_req = 1'b0; dma_we = 1'b0;
    step(1);
    check("t5_dma_ack", dma_ack, 0);
    check("t5_owner", owner, 0);
    check("t5_ram_en", ram_en, 0);
    check("t5_ram_we", ram_we, 0);
    check("t5_ram_addr", ram_addr, 0);
    check("t5_ram_wdata", ram_wdata, 0);
    check("t5_dma_rdata", dma_rdata, 0);
    check("t5_mem_0100", mem[16'h0100], 16'hCAFE);
    rst_n = 1'b1;
    cpu_req = 1'b1; cpu_addr = 16'h1234;
    dma_req = 1'b1; dma_addr = 16'h0100;
    step(1);
    check("t5_tie_cpu", owner, 1);
    step(1);
    check("t5_tie_ack", cpu_ack, 1);
    cpu_req = 1'b0;
    step(3);
    check("t5_dma_ack2", dma_ack, 1);
    check("t5_dma_rdata2", dma_rdata, 16'hCAFE);
    dma_req = 1'b0;
    step(1);

    // Reset clears a held lock: lone DMA request is served afterwards
    clear_inputs();
    cpu_req = 1'b1; cpu_lock = 1'b1; cpu_addr = 16'h1234;
    step(2);
    check("t6_cpu_ack", cpu_ack, 1);
    clear_inputs();
    step(1);
    do_reset();
    dma_req = 1'b1; dma_addr = 16'h1234;
    step(1);
    check("t6_owner_dma", owner, 2);
    step(1);
    check("t6_dma_ack", dma_ack, 1);
    check("t6_dma_rdata", dma_rdata, 16'hBEEF);
    dma_req = 1'b0;
    step(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
